// File: rtl/neuron_mac.sv
// Single fixed-point neuron: streamed x * ROM weight MAC, bias, optional ReLU, saturation.
// Define NEURON_RELU_EN for a ReLU activation; otherwise the output is linear.
module neuron_mac #(
  parameter int unsigned num_weight    = 3,
  parameter int unsigned neuron_no     = 5,
  parameter int unsigned layer_no      = 1,
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 16,
  parameter int unsigned frac_bits     = 8,
  parameter logic signed [data_width-1:0] bias = '0,
  parameter string       weight_file   = "../../../../weights/weight_test.mif",
  // ROM image built from weight_file; word i sits at bits [i*data_width +: data_width]
  parameter logic [num_weight*data_width-1:0] weight_init = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic signed [data_width-1:0] x_in,
  input  logic                         x_valid,
  output logic                         x_ready,
  output logic signed [data_width-1:0] y_out,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic                         busy
);

  localparam int unsigned prod_w = 2 * data_width;
  localparam int unsigned acc_w  = 2 * data_width + $clog2(num_weight) + 1;
  localparam int unsigned depth  = 2 ** address_width;

  typedef logic signed [prod_w-1:0] prod_t;
  typedef logic signed [acc_w-1:0]  acc_t;
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

  localparam logic [address_width-1:0] last_idx = address_width'(num_weight - 1);
  localparam acc_t max_v    = acc_t'({1'b0, {(data_width-1){1'b1}}});
  localparam acc_t min_v    = ~max_v;
  localparam acc_t bias_ext = acc_t'(bias) << frac_bits;

  state_t state, state_nx;
  logic [address_width-1:0] cnt, cnt_nx;
  acc_t  acc, acc_nx;
  logic  v0, v1, v2, v0_nx, v1_nx, v2_nx;
  logic  hs;
  logic signed [data_width-1:0] x_d, x_r, w_q, w_r;
  prod_t prod, prod_c;
  acc_t  sum_c, sh_c, act_c;
  logic signed [data_width-1:0] sat_c, y_out_nx;
  logic  y_valid_nx, x_ready_nx, busy_nx;
  logic [data_width-1:0] rom [depth];

  // Constant weight table; addresses beyond num_weight read as zero
  for (genvar i = 0; i < depth; i++) begin : g_rom
    if (i < num_weight) begin : g_word
      assign rom[i] = weight_init[i*data_width +: data_width];
    end else begin : g_zero
      assign rom[i] = '0;
    end
  end

  // Datapath: product, bias, floor shift, activation, clamp
  always_comb begin
    prod_c = prod_t'(x_r) * prod_t'(w_r);
    sum_c  = acc + bias_ext;
    sh_c   = sum_c >>> frac_bits;
`ifdef NEURON_RELU_EN
    act_c  = sh_c[acc_w-1] ? '0 : sh_c;
`else
    act_c  = sh_c;
`endif
    if (act_c > max_v)      sat_c = data_width'(max_v);
    else if (act_c < min_v) sat_c = data_width'(min_v);
    else                    sat_c = data_width'(act_c);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    acc_nx     = acc;
    y_out_nx   = y_out;
    y_valid_nx = y_valid;
    hs         = x_valid && x_ready;
    v0_nx      = hs;
    v1_nx      = v0;
    v2_nx      = v1;
    if (v2) acc_nx = acc + acc_t'(prod);

    case (state)
      ACCUM: begin
        if (hs) begin
          cnt_nx = cnt + address_width'(1);
          if (cnt == last_idx) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // acc is final once no product remains in flight
        if (!v0 && !v1 && !v2) begin
          state_nx   = OUT;
          y_out_nx   = sat_c;
          y_valid_nx = 1'b1;
        end
      end
      OUT: begin
        if (y_ready) begin
          state_nx   = ACCUM;
          cnt_nx     = '0;
          acc_nx     = '0;
          y_valid_nx = 1'b0;
        end
      end
      default: state_nx = ACCUM;
    endcase

    if (flush) begin
      state_nx   = ACCUM;
      cnt_nx     = '0;
      acc_nx     = '0;
      v0_nx      = 1'b0;
      v1_nx      = 1'b0;
      v2_nx      = 1'b0;
      y_valid_nx = 1'b0;
    end

    x_ready_nx = (state_nx == ACCUM);
    busy_nx    = (cnt_nx != '0) || v0_nx || v1_nx || v2_nx || (state_nx != ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc     <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      x_d     <= '0;
      w_q     <= '0;
      x_r     <= '0;
      w_r     <= '0;
      prod    <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      x_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      acc     <= acc_nx;
      v0      <= v0_nx;
      v1      <= v1_nx;
      v2      <= v2_nx;
      if (hs) begin
        x_d <= x_in;
        w_q <= rom[cnt];
      end
      x_r     <= x_d;
      w_r     <= w_q;
      prod    <= prod_c;
      y_out   <= y_out_nx;
      y_valid <= y_valid_nx;
      x_ready <= x_ready_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: weights 1.0, 2.0, -1.0 and bias 0.5 in Q8.8.
module tb_neuron_mac;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] x_in;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_out;
  logic        y_valid;
  logic        y_ready;
  logic        busy;

  int total;
  int passed;

`ifdef NEURON_RELU_EN
  localparam logic [15:0] exp_neg = 16'h0000;
  localparam logic [15:0] exp_min = 16'h0000;
`else
  localparam logic [15:0] exp_neg = 16'hFC80;
  localparam logic [15:0] exp_min = 16'h8000;
`endif

  neuron_mac #(
    .num_weight(3), .neuron_no(5), .layer_no(1), .address_width(10),
    .data_width(16), .frac_bits(8), .bias(16'h0080),
    .weight_file("weight_test.mif"),
    .weight_init({16'hFF00, 16'h0200, 16'h0100})
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [15:0] v);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    x_in = v;
    x_valid = 1'b1;
    while (!done && t < 20) begin
      done = x_ready;
      @(negedge clk);
      t++;
    end
    if (!done) begin
      total++;
      $display("FAIL push_timeout: x_ready stayed 0 for sample %h", v);
    end
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input int gap, output logic [15:0] y, output int lat,
                           output logic xr_after);
    logic [15:0] v [3];
    v = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      push(v[i]);
      if (gap > 0 && i < 2) begin
        x_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    x_valid = 1'b0;
    xr_after = x_ready;
    lat = 0;
    while (!y_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!y_valid) begin
      total++;
      $display("FAIL y_timeout: y_valid never rose after frame %h %h %h", a, b, c);
    end
    y = y_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({y_valid, busy, y_out} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_outputs: got y_valid=%b busy=%b y_out=%h want 0 0 0000", y_valid, busy, y_out);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (x_ready !== 1'b1) $display("FAIL reset_x_ready: got %b want 1", x_ready);
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] y;
    int lat;
    logic xr;
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    total++;
    if (y !== 16'h0280) $display("FAIL basic_y: got %h want 0280", y); else passed++;
    total++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else passed++;
    total++;
    if (xr !== 1'b0) $display("FAIL basic_drain_x_ready: got %b want 0", xr); else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL basic_busy_out: got %b want 1", busy); else passed++;
    @(negedge clk);
    total++;
    if ({y_valid, x_ready, busy} !== 3'b010)
      $display("FAIL basic_after: got y_valid=%b x_ready=%b busy=%b want 0 1 0", y_valid, x_ready, busy);
    else passed++;
  endtask

  task automatic test_negative();
    logic [15:0] y;
    int lat;
    logic xr;
    run_frame(16'h0000, 16'h0000, 16'h0400, 0, y, lat, xr);
    total++;
    if (y !== exp_neg) $display("FAIL negative_y: got %h want %h", y, exp_neg); else passed++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [15:0] y;
    int lat;
    logic xr;
    run_frame(16'h7F00, 16'h7F00, 16'h7F00, 0, y, lat, xr);
    total++;
    if (y !== 16'h7FFF) $display("FAIL sat_max_y: got %h want 7FFF", y); else passed++;
    @(negedge clk);
    run_frame(16'h8000, 16'h8000, 16'h7F00, 0, y, lat, xr);
    total++;
    if (y !== exp_min) $display("FAIL sat_min_y: got %h want %h", y, exp_min); else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] y;
    int lat;
    logic xr;
    y_ready = 1'b0;
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({y_valid, x_ready, busy, y_out} !== {1'b1, 1'b0, 1'b1, 16'h0280})
        $display("FAIL hold_cycle%0d: got y_valid=%b x_ready=%b busy=%b y_out=%h want 1 0 1 0280",
                 i, y_valid, x_ready, busy, y_out);
      else passed++;
    end
    y_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({y_valid, x_ready} !== 2'b01)
      $display("FAIL hold_release: got y_valid=%b x_ready=%b want 0 1", y_valid, x_ready);
    else passed++;
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    total++;
    if (y !== 16'h0280) $display("FAIL hold_next_y: got %h want 0280", y); else passed++;
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [15:0] y;
    int lat;
    logic xr;
    run_frame(16'h0100, 16'h0100, 16'h0100, 2, y, lat, xr);
    total++;
    if (y !== 16'h0280) $display("FAIL gaps_y: got %h want 0280", y); else passed++;
    total++;
    if (lat !== 4) $display("FAIL gaps_latency: got %0d want 4", lat); else passed++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [15:0] y;
    int lat;
    logic xr;
    push(16'h0300);
    push(16'h0300);
    x_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if ({busy, x_ready} !== 2'b01)
      $display("FAIL flush_idle: got busy=%b x_ready=%b want 0 1", busy, x_ready);
    else passed++;
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    total++;
    if (y !== 16'h0280) $display("FAIL flush_next_y: got %h want 0280", y); else passed++;
    @(negedge clk);
    // flush while a result waits for y_ready
    y_ready = 1'b0;
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    y_ready = 1'b1;
    total++;
    if ({y_valid, x_ready, busy} !== 3'b010)
      $display("FAIL flush_pending: got y_valid=%b x_ready=%b busy=%b want 0 1 0", y_valid, x_ready, busy);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] y;
    int lat;
    logic xr;
    push(16'h0500);
    push(16'h0500);
    x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, y_valid} !== 2'b00)
      $display("FAIL async_reset: got busy=%b y_valid=%b want 0 0", busy, y_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(16'h0100, 16'h0100, 16'h0100, 0, y, lat, xr);
    total++;
    if (y !== 16'h0280) $display("FAIL reset_next_y: got %h want 0280", y); else passed++;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    passed = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    x_in = '0;
    x_valid = 1'b0;
    y_ready = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_flush();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter num_weight, default 3: inputs (and weights) per frame, >=1.
REQ-002 Parameter neuron_no, default 5: neuron index within its layer.
REQ-003 Parameter layer_no, default 1: layer index.
REQ-004 Parameter address_width, default 10: weight memory address width; 2**address_width >= num_weight.
REQ-005 Parameter data_width, default 16: signed two's-complement width of x, w, bias, y.
REQ-006 Parameter frac_bits, default 8: fractional bits of the fixed-point format, < data_width.
REQ-007 Parameter bias, default 0: signed data_width bias, same fixed-point format.
REQ-008 Parameter weight_file, default "../../../../weights/weight_test.mif": weights loaded at elaboration, word i at address i.
REQ-009 clk  in  1  single clock; all state on rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 flush  in  1  synchronous abort of the current frame.
REQ-012 x_in  in  data_width  signed input sample.
REQ-013 x_valid  in  1  x_in valid.
REQ-014 x_ready  out  1  neuron accepts x_in this cycle.
REQ-015 y_out  out  data_width  signed activated result.
REQ-016 y_valid  out  1  y_out valid.
REQ-017 y_ready  in  1  downstream accepts y_out.
REQ-018 busy  out  1  frame in progress or result pending.

Function
REQ-019 Input handshake = x_valid && x_ready at a rising edge; the k-th handshake of a frame (k = 0..num_weight-1) is multiplied by weight word k.
REQ-020 Weight memory: internal synchronous-read ROM, one-cycle read latency, addressed by an address_width-bit sample counter.
REQ-021 States: ACCUM (x_ready=1 while counter < num_weight), DRAIN (x_ready=0, pipeline emptying), OUT (y_valid=1, x_ready=0).
REQ-022 Pipeline: edge E0 handshake; E1 weight and aligned x registered; E2 full-precision product (2*data_width) registered; E3 product added to accumulator.
REQ-023 Accumulator width 2*data_width + clog2(num_weight) + 1; no overflow inside the frame.
REQ-024 x_valid gaps mid-frame: pipeline valid bits stall accumulation with no loss or duplication.
REQ-025 After the num_weight-th handshake: ACCUM->DRAIN; at E4: y_out = sat(act((acc + (bias << frac_bits)) >>> frac_bits)), y_valid=1, state OUT.
REQ-026 Shift is arithmetic (rounds toward negative infinity); sat clamps to [-2**(data_width-1), 2**(data_width-1)-1].
REQ-027 OUT: y_out and y_valid held stable until y_valid && y_ready; that edge clears accumulator and counter and enters ACCUM; x_ready rises next cycle.
REQ-028 flush (highest priority over handshakes): clears counter, accumulator, pipeline valids, y_valid; state ACCUM next cycle; a pending y_out is discarded.
REQ-029 busy = 1 when counter != 0, pipeline non-empty, or state DRAIN/OUT.

Reset
REQ-030 rst_n low asynchronously forces: state ACCUM, counter 0, accumulator 0, pipeline valids 0, y_out 0, y_valid 0, busy 0; x_ready = 1 after rst_n rises.
REQ-031 Reset mid-frame or mid-OUT abandons all partial results; the first handshake after reset is sample 0.

Configuration
REQ-032 Macro NEURON_RELU_EN defined: act(v) = 0 for v < 0, else v (applied before saturation).
REQ-033 NEURON_RELU_EN undefined: act is identity (linear output, negative values pass through).

Verification (num_weight=3, data_width=16, frac_bits=8, weights 0x0100, 0x0200, 0xFF00, bias 0x0080)
REQ-034 Inputs 0x0100,0x0100,0x0100 back-to-back, y_ready=1 -> y_out=0x0280, y_valid high exactly 4 cycles after the 3rd handshake, for 1 cycle.
REQ-035 Inputs 0x0000,0x0000,0x0400 -> NEURON_RELU_EN: y_out=0x0000; without: y_out=0xFC80.
REQ-036 Inputs 0x7F00 x3 -> y_out=0x7FFF (saturated); inputs 0x8000,0x8000,0x7F00 -> without RELU y_out=0x8000.
REQ-037 y_ready held 0 for 5 cycles after y_valid -> y_out stable, x_ready=0, busy=1; y_ready=1 -> x_ready=1 next cycle, next frame correct.
REQ-038 x_valid gaps of 2 cycles between samples, then repeat REQ-034 inputs -> y_out=0x0280.
REQ-039 flush or rst_n low after 2nd handshake, then REQ-034 inputs -> y_out=0x0280 (no carry-over).
